// File: rtl/bram_adapter_pkg.sv
// Shared types and helpers for the BRAM request adapter and its FIFO.
package bram_adapter_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  localparam int unsigned REQ_NB_COL    = 4;
  localparam int unsigned REQ_COL_WIDTH = 8;
  localparam int unsigned REQ_RAM_DEPTH = 512;
  localparam int unsigned ADDR_W        = clog2(REQ_RAM_DEPTH);
  localparam int unsigned DATA_W        = REQ_NB_COL * REQ_COL_WIDTH;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [REQ_NB_COL-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head; holds the
// last head value while empty.
module sync_fifo
  import bram_adapter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push_c, do_pop_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign rdata     = rdata_q;
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  // Head register tracks whichever entry will be at the front after this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    if (do_push_c) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    if (do_push_c && (count_q == CNT_W'(do_pop_c))) begin
      rdata_d = wdata;
    end else if (do_pop_c && (count_d != '0)) begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bram_req_adapter.sv
// Valid/ready request front end for one byte-enable BRAM port; tracks the fixed
// read latency and returns read data through a credit-guarded response FIFO.
module bram_req_adapter
  import bram_adapter_pkg::*;
#(
  parameter int unsigned NB_COL       = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH    = 512,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RSP_DEPTH    = READ_LATENCY + 2,
  localparam int unsigned AW = clog2(RAM_DEPTH),
  localparam int unsigned DW = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [NB_COL-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     bram_addr,
  output logic [DW-1:0]     bram_din,
  output logic [NB_COL-1:0] bram_we,
  output logic              bram_en,
  output logic              bram_regce,
  output logic              bram_rst,
  input  logic [DW-1:0]     bram_dout
);

  localparam int unsigned CW = clog2(RSP_DEPTH + 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_req_adapter: READ_LATENCY must be 1 or 2");
  end
  if (RSP_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("bram_req_adapter: RSP_DEPTH must be at least READ_LATENCY+1");
  end

  logic                    fire_c, rd_fire_c, push_c, pop_c;
  logic                    fifo_empty, fifo_full;
  logic [CW-1:0]           fifo_count;
  logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]           credits_q, credits_d;

  // Writes never need response space; reads need a free credit.
  assign req_ready = ~rst & (req_we | (credits_q != '0));
  assign fire_c    = req_valid & req_ready;
  assign rd_fire_c = fire_c & ~req_we;

  assign bram_en    = fire_c;
  assign bram_addr  = req_addr;
  assign bram_din   = req_wdata;
  assign bram_we    = (fire_c & req_we) ? req_wstrb : '0;
  assign bram_regce = 1'b1;
  assign bram_rst   = rst;

  assign push_c    = vpipe_q[READ_LATENCY-1];
  assign rsp_valid = ~fifo_empty;
  assign pop_c     = rsp_valid & rsp_ready;

  always_comb begin
    vpipe_d   = READ_LATENCY'({vpipe_q, rd_fire_c});
    credits_d = credits_q;
    case ({rd_fire_c, pop_c})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q   <= '0;
      credits_q <= CW'(RSP_DEPTH);
    end else begin
      vpipe_q   <= vpipe_d;
      credits_q <= credits_d;
    end
  end

  sync_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (bram_dout),
    .pop   (pop_c),
    .rdata (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Every credit is either free, waiting in the FIFO, or riding the pipeline.
  credit_conservation_a: assert property (@(posedge clk) disable iff (rst)
    (32'(credits_q) + 32'(fifo_count) + 32'($countones(vpipe_q))) == 32'(RSP_DEPTH));
  credit_bound_a: assert property (@(posedge clk) disable iff (rst)
    credits_q <= CW'(RSP_DEPTH));
  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_c && fifo_full && !pop_c));

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed bench for bram_req_adapter: instance 0 uses READ_LATENCY=2, instance 1
// uses READ_LATENCY=1, each driving a write-first behavioural BRAM.
module tb_bram_req_adapter;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [8:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic [8:0]  b_addr    [2];
  logic [31:0] b_din     [2];
  logic [3:0]  b_we      [2];
  logic        b_en      [2];
  logic        b_regce   [2];
  logic        b_rst     [2];
  logic [31:0] b_dout    [2];

  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (w[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [512];
    logic [31:0] s1, s2;

    bram_req_adapter #(
      .READ_LATENCY (g == 0 ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .bram_addr  (b_addr[g]),
      .bram_din   (b_din[g]),
      .bram_we    (b_we[g]),
      .bram_en    (b_en[g]),
      .bram_regce (b_regce[g]),
      .bram_rst   (b_rst[g]),
      .bram_dout  (b_dout[g])
    );

    always @(posedge clk) begin
      if (b_en[g]) begin
        mem[b_addr[g]] <= merge(mem[b_addr[g]], b_din[g], b_we[g]);
        s1             <= merge(mem[b_addr[g]], b_din[g], b_we[g]);
      end
      s2 <= b_rst[g] ? 32'h0 : s1;
    end
    assign b_dout[g] = (g == 0) ? s2 : s1;
  end

  // One clock of stimulus; outputs are sampled at the falling edge.
  task automatic cyc(input int u, input logic v, input logic we, input logic [8:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic rr,
                     output logic f, output logic en, output logic [3:0] bwe,
                     output logic rv, output logic [31:0] rd);
    req_valid[u] = v;
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = d;
    req_wstrb[u] = s;
    rsp_ready[u] = rr;
    @(negedge clk);
    f   = v & req_ready[u];
    en  = b_en[u];
    bwe = b_we[u];
    rv  = rsp_valid[u];
    rd  = rsp_rdata[u];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int u);
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd;
    rst[u] = 1'b1;
    cyc(u, 1'b1, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if (f !== 1'b0) $display("FAIL reset_read_ready u=%0d got %b exp 0", u, f); else n_pass++;
    cyc(u, 1'b1, 1'b1, 9'h000, 32'h0, 4'hF, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if ({f, en, bwe} !== 6'b0)
      $display("FAIL reset_bram_drive u=%0d got ready/en/we=%b/%b/%h exp 0/0/0", u, f, en, bwe);
    else n_pass++;
    rst[u] = 1'b0;
    cyc(u, 1'b1, 1'b1, 9'h000, 32'h12345678, 4'h0, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if ({f, en, bwe} !== 6'b110000)
      $display("FAIL zero_strb_write u=%0d got fire/en/we=%b/%b/%h exp 1/1/0", u, f, en, bwe);
    else n_pass++;
    n_total++;
    if ({rv, rd} !== 33'b0)
      $display("FAIL reset_rsp u=%0d got valid/data=%b/%h exp 0/00000000", u, rv, rd);
    else n_pass++;
  endtask

  task automatic test_write_read(input int u);
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd, data;
    int lat, rl;
    rl   = (u == 0) ? 2 : 1;
    lat  = 0;
    data = 32'h0;
    cyc(u, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if ({f, bwe} !== 5'b11111)
      $display("FAIL wr_fire u=%0d got fire/we=%b/%h exp 1/f", u, f, bwe);
    else n_pass++;
    cyc(u, 1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if (f !== 1'b1) $display("FAIL rd_fire u=%0d got %b exp 1", u, f); else n_pass++;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      cyc(u, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (rv) begin
        lat  = i;
        data = rd;
      end
    end
    n_total++;
    if (lat !== rl + 1) $display("FAIL rd_latency u=%0d got %0d exp %0d", u, lat, rl + 1);
    else n_pass++;
    n_total++;
    if (data !== 32'hDEADBEEF) $display("FAIL rd_data u=%0d got %h exp deadbeef", u, data);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd, data;
    int lat;
    lat  = 0;
    data = 32'h0;
    cyc(0, 1'b1, 1'b1, 9'h010, 32'h11223344, 4'b0101, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if (bwe !== 4'b0101) $display("FAIL partial_we got %b exp 0101", bwe); else n_pass++;
    cyc(0, 1'b1, 1'b0, 9'h010, 32'h0, 4'hF, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if (bwe !== 4'b0000) $display("FAIL read_ignores_strb got %b exp 0000", bwe); else n_pass++;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (rv) begin
        lat  = i;
        data = rd;
      end
    end
    n_total++;
    if (data !== 32'hDE22BE44) $display("FAIL partial_data got %h exp de22be44", data);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int u);
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd;
    int rl, n_rx, first;
    rl    = (u == 0) ? 2 : 1;
    n_rx  = 0;
    first = -1;
    for (int a = 0; a < 10; a++)
      cyc(u, 1'b1, 1'b1, 9'(a), 32'(a), 4'hF, 1'b1, f, en, bwe, rv, rd);
    for (int i = 0; i < 14; i++) begin
      cyc(u, i < 8, 1'b0, 9'(i), 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (i < 8) begin
        n_total++;
        if (f !== 1'b1) $display("FAIL b2b_ready u=%0d i=%0d got %b exp 1", u, i, f);
        else n_pass++;
      end
      if (rv) begin
        if (n_rx == 0) first = i;
        n_total++;
        if (rd !== 32'(n_rx) || i !== first + n_rx)
          $display("FAIL b2b_rsp u=%0d cycle=%0d got %h exp %h at cycle %0d",
                   u, i, rd, n_rx, first + n_rx);
        else n_pass++;
        n_rx++;
      end
    end
    n_total++;
    if (n_rx !== 8) $display("FAIL b2b_count u=%0d got %0d exp 8", u, n_rx); else n_pass++;
    n_total++;
    if (first !== rl + 1) $display("FAIL b2b_first u=%0d got %0d exp %0d", u, first, rl + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd;
    int acc, n_rx;
    acc  = 0;
    n_rx = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b1, 1'b0, 9'(acc), 32'h0, 4'h0, 1'b0, f, en, bwe, rv, rd);
      n_total++;
      if (f !== (i < 4)) $display("FAIL bp_ready i=%0d got %b exp %b", i, f, i < 4);
      else n_pass++;
      if (f) acc++;
    end
    n_total++;
    if (acc !== 4) $display("FAIL bp_accepted got %0d exp 4", acc); else n_pass++;
    cyc(0, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D, 4'hF, 1'b0, f, en, bwe, rv, rd);
    n_total++;
    if (f !== 1'b1) $display("FAIL bp_write got %b exp 1", f); else n_pass++;
    n_total++;
    if ({rv, rd} !== {1'b1, 32'h0})
      $display("FAIL bp_head got valid/data=%b/%h exp 1/00000000", rv, rd);
    else n_pass++;
    for (int i = 0; i < 40 && n_rx < 10; i++) begin
      cyc(0, acc < 10, 1'b0, 9'(acc), 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (f) acc++;
      if (rv) begin
        n_total++;
        if (rd !== 32'(n_rx)) $display("FAIL bp_order idx=%0d got %h exp %h", n_rx, rd, n_rx);
        else n_pass++;
        n_rx++;
      end
    end
    n_total++;
    if (n_rx !== 10 || acc !== 10)
      $display("FAIL bp_total got rx/acc=%0d/%0d exp 10/10", n_rx, acc);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      n_total++;
      if (rv !== 1'b0) $display("FAIL bp_extra i=%0d got %b exp 0", i, rv); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    logic f, en, rv;
    logic [3:0] bwe;
    logic [31:0] rd;
    int stale, acc, n_rx;
    stale = 0;
    acc   = 0;
    n_rx  = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b1, 1'b0, 9'(i + 5), 32'h0, 4'h0, 1'b0, f, en, bwe, rv, rd);
      n_total++;
      if (f !== 1'b1) $display("FAIL mid_fill i=%0d got %b exp 1", i, f); else n_pass++;
    end
    rst[0] = 1'b1;
    cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b0, f, en, bwe, rv, rd);
    rst[0] = 1'b0;
    cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
    n_total++;
    if ({rv, rd} !== 33'b0)
      $display("FAIL mid_rsp_cleared got valid/data=%b/%h exp 0/00000000", rv, rd);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (rv) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL mid_stale got %0d exp 0", stale); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b1, 1'b0, 9'h007, 32'h0, 4'h0, 1'b0, f, en, bwe, rv, rd);
      if (f) acc++;
    end
    n_total++;
    if (acc !== 4) $display("FAIL mid_credits got %0d exp 4", acc); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, f, en, bwe, rv, rd);
      if (rv) begin
        n_total++;
        if (rd !== 32'h7) $display("FAIL mid_data idx=%0d got %h exp 00000007", n_rx, rd);
        else n_pass++;
        n_rx++;
      end
    end
    n_total++;
    if (n_rx !== 4) $display("FAIL mid_drain got %0d exp 4", n_rx); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int u = 0; u < 2; u++) begin
      rst[u]       = 1'b1;
      req_valid[u] = 1'b0;
      req_we[u]    = 1'b0;
      req_addr[u]  = 9'h0;
      req_wdata[u] = 32'h0;
      req_wstrb[u] = 4'h0;
      rsp_ready[u] = 1'b0;
    end
    @(posedge clk);
    #1;
    test_reset(0);
    test_write_read(0);
    test_partial_write();
    test_back_to_back(0);
    test_backpressure();
    test_reset_midop();
    test_reset(1);
    test_write_read(1);
    test_back_to_back(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
